// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory controller and its byte-lane RAM.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic WE_WRITE = 1'b1;
  localparam logic WE_READ  = 1'b0;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = WORD_W / LANES;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// Single-port word RAM with four byte lanes, synchronous read and per-lane write enables.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        en_i,
  input  logic                        we_i,
  input  logic [LANES-1:0]            be_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [WORD_W-1:0]           wdata_i,
  output logic [WORD_W-1:0]           rdata_o
);

  logic [LANES-1:0][LANE_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0]            rdata_q;

  // NOTE: the array has no reset; clearing every word would force it into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < LANES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][i] <= wdata_i[i*LANE_W +: LANE_W];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: captures one core request, waits WAIT_STATES cycles, then commits and pulses valid.
// Optional bounds checking (suppress + error pulse) is enabled by defining DATA_MEM_BOUNDS_CHECK_EN.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        valid,
  output logic        busy,
  output logic        error
);

  localparam int         AW = idx_width(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic              we_q;
  logic [LANES-1:0]  mask_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] data_q;
  logic              oob_q;
  logic              zero_q;

  logic [AW-1:0]     idx_in;
  logic              oob_in;

  logic              fresh;
  logic              commit;
  logic              acc_we;
  logic [LANES-1:0]  acc_mask;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_data;
  logic              acc_oob;
  logic [WORD_W-1:0] mem_rdata;

  // Offset from the window base; truncation to AW bits gives the modulo-depth wrap.
  assign idx_in = AW'((address - BASE_ADDR) >> 2);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign oob_in = ({1'b0, address} <  {1'b0, BASE_ADDR}) ||
                  ({1'b0, address} >= ({1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS)));
`else
  assign oob_in = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (WS == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WS) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    valid = (state_q == RESP);
    busy  = (state_q != IDLE);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    error = (state_q == RESP) && oob_q;
`else
    error = 1'b0;
`endif
  end

  // Request capture; contents only matter while busy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && request) begin
      we_q   <= we_re;
      mask_q <= mask;
      idx_q  <= idx_in;
      data_q <= store_data;
      oob_q  <= oob_in;
    end
  end

  // With zero wait states the commit edge is the capture edge, so the live inputs feed the RAM.
  always_comb begin
    fresh    = (state_q == IDLE);
    acc_we   = fresh ? we_re      : we_q;
    acc_mask = fresh ? mask       : mask_q;
    acc_idx  = fresh ? idx_in     : idx_q;
    acc_data = fresh ? store_data : data_q;
    acc_oob  = fresh ? oob_in     : oob_q;
    commit   = 1'b0;
    if (!rst) begin
      if (fresh && request && (WS == 4'd0)) begin
        commit = 1'b1;
      end else if (state_q == WAIT && cnt_q == WS) begin
        commit = 1'b1;
      end
    end
  end

  // zero_q forces load_data to 0 after reset and after a suppressed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else if (commit && acc_we == WE_READ) begin
      zero_q <= acc_oob;
    end
  end

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .en_i    (commit && !acc_oob),
    .we_i    (acc_we == WE_WRITE),
    .be_i    (acc_mask),
    .addr_i  (acc_idx),
    .wdata_i (acc_data),
    .rdata_o (mem_rdata)
  );

  assign load_data = zero_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with one wait state, one with none.
module tb_data_mem_ctrl;
  import data_mem_pkg::*;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_s, we_s, vld_s, bsy_s, err_s;
  logic [3:0]  msk_s  [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] ld_s   [2];

  exp_t        sb0[$], sb1[$];
  logic [31:0] model  [2][DEPTH];
  logic [31:0] last_rd[2];
  int          vcnt   [2];
  int          negcnt = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_ws0 (
    .clk(clk), .rst(rst), .request(req_s[0]), .we_re(we_s[0]), .mask(msk_s[0]),
    .address(addr_s[0]), .store_data(wd_s[0]), .load_data(ld_s[0]),
    .valid(vld_s[0]), .busy(bsy_s[0]), .error(err_s[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) dut_ws1 (
    .clk(clk), .rst(rst), .request(req_s[1]), .we_re(we_s[1]), .mask(msk_s[1]),
    .address(addr_s[1]), .store_data(wd_s[1]), .load_data(ld_s[1]),
    .valid(vld_s[1]), .busy(bsy_s[1]), .error(err_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic oob_f(input logic [31:0] a);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    return (a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * DEPTH)));
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: updates the word image and returns what the response must show.
  task automatic predict(input int d, input logic w, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    logic [31:0] off, word;
    int          ix;
    off  = (a - BASE) >> 2;
    ix   = int'(off & 32'(DEPTH - 1));
    word = model[d][ix];
    e.err = oob_f(a);
    e.cap = negcnt;
    if (w == WE_WRITE) begin
      if (!e.err) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) word[i*8 +: 8] = wd[i*8 +: 8];
        end
        model[d][ix] = word;
      end
      e.data = last_rd[d];
    end else begin
      e.data     = e.err ? 32'h0 : word;
      last_rd[d] = e.data;
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] wd);
    req_s[d]  = r;
    we_s[d]   = w;
    msk_s[d]  = m;
    addr_s[d] = a;
    wd_s[d]   = wd;
  endtask

  // One isolated access: drive, capture, predict, then measure how long busy stays high.
  task automatic access(input int d, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    @(negedge clk);
    drive(d, 1'b1, w, m, a, wd);
    @(posedge clk);
    predict(d, w, m, a, wd, e);
    push(d, e);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    while (bsy_s[d] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("busy_len_d%0d", d), 32'(n), 32'(d + 1));
  endtask

  // Scoreboard side: every valid must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    negcnt++;
    for (int d = 0; d < 2; d++) begin
      if (vld_s[d] === 1'b1) begin
        vcnt[d]++;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          check($sformatf("spurious_valid_d%0d", d), 32'(vld_s[d]), 32'h0);
        end else begin
          e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("load_data_d%0d", d), ld_s[d], e.data);
          check($sformatf("error_d%0d", d), 32'(err_s[d]), 32'(e.err));
          check($sformatf("latency_d%0d", d), 32'(negcnt - e.cap), 32'(d + 1));
        end
      end
    end
  end

  initial begin
    int   base;
    exp_t e;
    rst = 1'b1;
    vcnt[0] = 0;
    vcnt[1] = 0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid_d%0d", d), 32'(vld_s[d]), 32'h0);
      check($sformatf("rst_busy_d%0d", d),  32'(bsy_s[d]), 32'h0);
      check($sformatf("rst_error_d%0d", d), 32'(err_s[d]), 32'h0);
      check($sformatf("rst_load_d%0d", d),  ld_s[d], 32'h0);
    end

    // Write then read back with one wait state.
    access(1, WE_WRITE, 4'hF, 32'h10, 32'hDEAD_BEEF);
    access(1, WE_READ,  4'h0, 32'h10, 32'h0);
    check("rw_literal", ld_s[1], 32'hDEAD_BEEF);

    // Partial write, then an all-lanes-off write that must change nothing.
    access(1, WE_WRITE, 4'hF,    32'h20, 32'h1122_3344);
    access(1, WE_WRITE, 4'b0110, 32'h20, 32'hAABB_CCDD);
    check("write_keeps_load", ld_s[1], 32'hDEAD_BEEF);
    access(1, WE_READ,  4'hF,    32'h20, 32'h0);
    check("partial_literal", ld_s[1], 32'h11BB_CC44);
    access(1, WE_WRITE, 4'h0,    32'h20, 32'hFFFF_FFFF);
    access(1, WE_READ,  4'h3,    32'h20, 32'h0);
    check("mask0_literal", ld_s[1], 32'h11BB_CC44);

    // Reset asserted during the wait cycle of a write aborts it.
    access(1, WE_WRITE, 4'hF, 32'h8, 32'h0BAD_F00D);
    base = vcnt[1];
    @(negedge clk);
    drive(1, 1'b1, WE_WRITE, 4'hF, 32'h8, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    check("abort_busy", 32'(bsy_s[1]), 32'h0);
    check("abort_load", ld_s[1], 32'h0);
    repeat (3) @(negedge clk);
    check("abort_no_valid", 32'(vcnt[1] - base), 32'h0);
    access(1, WE_READ, 4'hF, 32'h8, 32'h0);
    check("abort_literal", ld_s[1], 32'h0BAD_F00D);

    // Address window edge: 0x1004 aliases word 1 unless bounds checking suppresses it.
    access(1, WE_WRITE, 4'hF, 32'h4,    32'h600D_CAFE);
    access(1, WE_WRITE, 4'hF, 32'h1004, 32'hCAFE_F00D);
    access(1, WE_READ,  4'hF, 32'h4,    32'h0);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    check("bounds_word1_kept", ld_s[1], 32'h600D_CAFE);
    access(1, WE_READ, 4'hF, 32'h1004, 32'h0);
    check("bounds_read_zero", ld_s[1], 32'h0);
`else
    check("wrap_literal", ld_s[1], 32'hCAFE_F00D);
    access(1, WE_READ, 4'hF, 32'h1004, 32'h0);
    check("wrap_alias_read", ld_s[1], 32'hCAFE_F00D);
`endif

    // Zero wait states, request held across RESP: exactly two captures.
    access(0, WE_WRITE, 4'hF, 32'h0, 32'hA5A5_0001);
    access(0, WE_WRITE, 4'hF, 32'h4, 32'h5A5A_0002);
    base = vcnt[0];
    @(negedge clk);
    drive(0, 1'b1, WE_READ, 4'hF, 32'h0, 32'h0);
    @(posedge clk);
    predict(0, WE_READ, 4'hF, 32'h0, 32'h0, e);
    push(0, e);
    @(negedge clk);
    drive(0, 1'b1, WE_READ, 4'hF, 32'h4, 32'h0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    predict(0, WE_READ, 4'hF, 32'h4, 32'h0, e);
    push(0, e);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    check("b2b_valid_count", 32'(vcnt[0] - base), 32'd2);
    check("b2b_last_literal", ld_s[0], 32'h5A5A_0002);

    repeat (4) @(negedge clk);
    check("sb0_drained", 32'(sb0.size()), 32'h0);
    check("sb1_drained", 32'(sb1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
